zuc_lfsr_core: RTL and testbench
================================

ZUC_LFSR_CORE -- requirements
Module: zuc_lfsr_core

Interface
REQ-001 Parameter STEPS, default 1, number of LFSR steps per accepted step_en (legal values 1 or 2).
REQ-002 Parameter INIT_ROUNDS, default 32, init-mode steps before work mode; SHALL be a multiple of STEPS.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 load_valid  in  1  request to load a new 16-cell state.
REQ-006 load_data  in  496  cell i at bits [31*i+30 : 31*i], i = 0..15.
REQ-007 load_ready  out  1  high in IDLE and WORK, low in INIT.
REQ-008 step_en  in  1  advance LFSR by STEPS steps this cycle.
REQ-009 u_in  in  31*STEPS  init-mode u values; u of step k at bits [31*k+30 : 31*k], k=0 first.
REQ-010 state_o  out  496  registered cells s0..s15, same packing as load_data.
REQ-011 work_o  out  1  high while in WORK.
REQ-012 init_done  out  1  one-cycle pulse on the INIT->WORK transition.
REQ-013 step_cnt  out  32  steps executed since last load (see Configuration).

Function
REQ-014 States IDLE, INIT, WORK; reset state IDLE.
REQ-015 load_valid && load_ready: cells <= load_data, round counter <= 0, state -> INIT; any step_en in the same cycle is dropped.
REQ-016 load_valid in INIT ignored; load_ready low.
REQ-017 step_en in IDLE ignored.
REQ-018 One step: v = (2^15 s15 + 2^17 s13 + 2^21 s10 + 2^20 s4 + (1+2^8) s0) mod (2^31-1), each term computed by 31-bit rotate and end-around-carry add.
REQ-019 Each end-around-carry add: 32-bit sum of two 31-bit operands, then low 31 bits plus bit 31.
REQ-020 INIT: s16 = v + u (end-around-carry); WORK: s16 = v, u_in ignored.
REQ-021 s16 equal to 0 SHALL be replaced with 0x7FFFFFFF, evaluated per step.
REQ-022 Shift: new s_i = old s_(i+1) for i = 0..14, new s15 = s16.
REQ-023 STEPS=2: second step operates on the result of the first, within one cycle, using u_in[61:31] in INIT.
REQ-024 Latency: state_o reflects an accepted step_en or load on the cycle after the edge.
REQ-025 INIT round counter += STEPS per accepted step_en; on reaching INIT_ROUNDS, state -> WORK on that same edge, init_done pulses the next cycle.
REQ-026 WORK is held until reset or a new load; no automatic return to IDLE.

Reset
REQ-027 rst high on a clock edge: state IDLE, all cells 0, round counter 0, step_cnt 0, work_o 0, init_done 0; load_ready 1.
REQ-028 rst takes priority over load_valid and step_en; reset mid-INIT or mid-WORK discards all progress.

Configuration
REQ-029 Macro ZUC_LFSR_STEP_CNT_EN defined: step_cnt increments by STEPS per accepted step_en, clears on load, wraps modulo 2^32.
REQ-030 Macro not defined: step_cnt tied to 0, no counter register; all other behaviour identical.

Verification
REQ-031 Load all cells 0, run INIT_ROUNDS steps with u=0, then one WORK step -> every new cell 0x7FFFFFFF (zero substitution).
REQ-032 Load s0=1, others 0, bypass INIT (INIT_ROUNDS steps of u=0 with cells checked), then from a WORK load path test s16: s0=1 only -> s16=0x00000101; s15=1 only -> s16=0x00008000.
REQ-033 STEPS=1: init_done pulses exactly 1 cycle after the 32nd accepted step_en; STEPS=2: after the 16th; work_o rises on that cycle.
REQ-034 load_valid during INIT -> ignored, state_o unchanged; load_valid and step_en same cycle in WORK -> load_data captured, no step, state INIT.
REQ-035 rst asserted after 10 INIT steps -> next cycle state_o=0, work_o=0, load_ready=1, step_cnt=0.
REQ-036 STEPS=2 vs STEPS=1 run on identical load_data/u sequence -> identical state_o after every second STEPS=1 step.

Source files
------------

// File: rtl/zuc_lfsr_core.sv
// rtl/zuc_lfsr_core.sv - ZUC 16-cell LFSR with IDLE/INIT/WORK modes, STEPS steps per cycle
// Optional step counter enabled by defining ZUC_LFSR_STEP_CNT_EN.
module zuc_lfsr_core #(
  parameter int STEPS       = 1,
  parameter int INIT_ROUNDS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [495:0]         load_data,
  output logic                 load_ready,
  input  logic                 step_en,
  input  logic [31*STEPS-1:0]  u_in,
  output logic [495:0]         state_o,
  output logic                 work_o,
  output logic                 init_done,
  output logic [31:0]          step_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_WORK} state_t;

  state_t       r_state;
  logic [495:0] r_cells;
  logic [31:0]  r_round;
  logic         r_load_ready;
  logic         r_work;
  logic         r_init_done;

  logic [495:0] w_chain [STEPS+1];
  logic         w_load;
  logic         w_step;
  logic [31:0]  w_round_nxt;

  function automatic logic [30:0] rot31(input logic [30:0] x, input int k);
    return (x << k) | (x >> (31 - k));
  endfunction

  // End-around-carry add: folding bit 31 back in reduces modulo 2^31-1.
  function automatic logic [30:0] add31(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[30:0] + {30'd0, s[31]};
  endfunction

  function automatic logic [495:0] lfsr_step(input logic [495:0] c, input logic [30:0] u,
                                             input logic init);
    logic [30:0] v;
    logic [30:0] s16;
    v = add31(add31(rot31(c[15*31 +: 31], 15), rot31(c[13*31 +: 31], 17)),
              add31(rot31(c[10*31 +: 31], 21), rot31(c[4*31 +: 31], 20)));
    v = add31(v, add31(c[0 +: 31], rot31(c[0 +: 31], 8)));
    s16 = init ? add31(v, u) : v;
    if (s16 == 31'd0) s16 = 31'h7FFFFFFF;
    return {s16, c[495:31]};
  endfunction

  assign w_chain[0] = r_cells;
  for (genvar k = 0; k < STEPS; k++) begin : g_step
    assign w_chain[k+1] = lfsr_step(w_chain[k], u_in[31*k +: 31], r_state == ST_INIT);
  end

  // A load wins over a step issued in the same cycle.
  assign w_load      = load_valid && r_load_ready;
  assign w_step      = step_en && !w_load && (r_state != ST_IDLE);
  assign w_round_nxt = r_round + 32'(STEPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cells      <= '0;
      r_round      <= '0;
      r_load_ready <= 1'b1;
      r_work       <= 1'b0;
      r_init_done  <= 1'b0;
    end else begin
      r_init_done <= 1'b0;
      if (w_load) begin
        r_cells      <= load_data;
        r_round      <= '0;
        r_state      <= ST_INIT;
        r_load_ready <= 1'b0;
        r_work       <= 1'b0;
      end else if (w_step) begin
        r_cells <= w_chain[STEPS];
        if (r_state == ST_INIT) begin
          r_round <= w_round_nxt;
          if (w_round_nxt >= 32'(INIT_ROUNDS)) begin
            r_state      <= ST_WORK;
            r_load_ready <= 1'b1;
            r_work       <= 1'b1;
            r_init_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign state_o    = r_cells;
  assign load_ready = r_load_ready;
  assign work_o     = r_work;
  assign init_done  = r_init_done;

`ifdef ZUC_LFSR_STEP_CNT_EN
  logic [31:0] r_step_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt <= '0;
    end else if (w_load) begin
      r_step_cnt <= '0;
    end else if (w_step) begin
      r_step_cnt <= r_step_cnt + 32'(STEPS);
    end
  end

  assign step_cnt = r_step_cnt;
`else
  assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_zuc_lfsr_core.sv
// tb/tb_zuc_lfsr_core.sv - self-checking bench for zuc_lfsr_core (STEPS=1 and STEPS=2 instances)
module tb_zuc_lfsr_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [495:0] load_data = '0;
  logic         lv1 = 1'b0, lv2 = 1'b0, se1 = 1'b0, se2 = 1'b0;
  logic [30:0]  u1 = '0;
  logic [61:0]  u2 = '0;
  logic [495:0] st1, st2;
  logic         lr1, lr2, wk1, wk2, id1, id2;
  logic [31:0]  sc1, sc2;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  logic [30:0]  mc [2][16];
  int           ms [2];
  int           mr [2];
  int unsigned  mcnt [2];
  bit           mdone [2];

  always #5 clk = ~clk;

  zuc_lfsr_core #(.STEPS(1), .INIT_ROUNDS(32)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_data(load_data), .load_ready(lr1),
    .step_en(se1), .u_in(u1), .state_o(st1), .work_o(wk1), .init_done(id1), .step_cnt(sc1));

  zuc_lfsr_core #(.STEPS(2), .INIT_ROUNDS(32)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_data(load_data), .load_ready(lr2),
    .step_en(se2), .u_in(u2), .state_o(st2), .work_o(wk2), .init_done(id2), .step_cnt(sc2));

  // Reference arithmetic: true weighted sum reduced mod 2^31-1, with 0 mapped to 2^31-1.
  function automatic logic [30:0] nxt(input logic [30:0] s0, input logic [30:0] s4,
                                      input logic [30:0] s10, input logic [30:0] s13,
                                      input logic [30:0] s15, input logic [30:0] u);
    longint unsigned t;
    t = (64'(s15) << 15) + (64'(s13) << 17) + (64'(s10) << 21) + (64'(s4) << 20)
        + 64'(s0) + (64'(s0) << 8) + 64'(u);
    t = t % 64'h7FFFFFFF;
    return (t == 0) ? 31'h7FFFFFFF : t[30:0];
  endfunction

  function automatic logic [495:0] mpack(input int d);
    logic [495:0] r;
    for (int i = 0; i < 16; i++) r[31*i +: 31] = mc[d][i];
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt(input int d);
`ifdef ZUC_LFSR_STEP_CNT_EN
    return mcnt[d];
`else
    return (d < 0) ? mcnt[0] : 32'd0;
`endif
  endfunction

  function automatic logic [30:0] useq(input int j);
    logic [31:0] t;
    t = (32'(j) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
    return t[30:0];
  endfunction

  task automatic model_edge(input int d);
    int          n;
    logic        lv, se;
    logic [30:0] uu [2];
    logic [30:0] s16;
    n = (d == 0) ? 1 : 2;
    lv = (d == 0) ? lv1 : lv2;
    se = (d == 0) ? se1 : se2;
    uu[0] = (d == 0) ? u1 : u2[30:0];
    uu[1] = u2[61:31];
    mdone[d] = 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) mc[d][i] = '0;
      ms[d] = 0; mr[d] = 0; mcnt[d] = 0;
    end else if (lv && ms[d] != 1) begin
      for (int i = 0; i < 16; i++) mc[d][i] = load_data[31*i +: 31];
      ms[d] = 1; mr[d] = 0; mcnt[d] = 0;
    end else if (se && ms[d] != 0) begin
      for (int k = 0; k < n; k++) begin
        s16 = nxt(mc[d][0], mc[d][4], mc[d][10], mc[d][13], mc[d][15],
                  (ms[d] == 1) ? uu[k] : 31'd0);
        for (int i = 0; i < 15; i++) mc[d][i] = mc[d][i+1];
        mc[d][15] = s16;
      end
      mcnt[d] += n;
      if (ms[d] == 1) begin
        mr[d] += n;
        if (mr[d] >= 32) begin ms[d] = 2; mdone[d] = 1'b1; end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_edge(d);
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("state1", 512'(st1), 512'(mpack(0)));
      chk("work1", 512'(wk1), 512'(ms[0] == 2));
      chk("ready1", 512'(lr1), 512'(ms[0] != 1));
      chk("done1", 512'(id1), 512'(mdone[0]));
      chk("cnt1", 512'(sc1), 512'(exp_cnt(0)));
      chk("state2", 512'(st2), 512'(mpack(1)));
      chk("work2", 512'(wk2), 512'(ms[1] == 2));
      chk("ready2", 512'(lr2), 512'(ms[1] != 1));
      chk("done2", 512'(id2), 512'(mdone[1]));
      chk("cnt2", 512'(sc2), 512'(exp_cnt(1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    run_cmp = 1'b1;
    chk("rst_state", 512'(st1), 512'd0);
    chk("rst_ready", 512'(lr1), 512'd1);
    chk("rst_work", 512'(wk1), 512'd0);
    chk("rst_cnt", 512'(sc1), 512'd0);

    se1 = 1'b1; tick(); se1 = 1'b0;
    chk("idle_step", 512'(st1), 512'd0);

    // All-zero load: every new cell must become 0x7FFFFFFF.
    load_data = '0; lv1 = 1'b1; tick(); lv1 = 1'b0;
    chk("init_ready", 512'(lr1), 512'd0);
    for (int j = 0; j < 32; j++) begin
      se1 = 1'b1; u1 = '0; tick();
      if (j == 0)  chk("zero_sub_init", 512'(st1[495:465]), 512'h7FFFFFFF);
      if (j == 30) chk("done_early", 512'(id1), 512'd0);
      if (j == 31) begin
        chk("done_32", 512'(id1), 512'd1);
        chk("work_32", 512'(wk1), 512'd1);
      end
    end
    tick();
    se1 = 1'b0;
    chk("zero_sub_work", 512'(st1), 512'({496{1'b1}}));
    chk("done_cleared", 512'(id1), 512'd0);

    // s0=1 only -> s16 = 0x101
    load_data = '0; load_data[0] = 1'b1; lv1 = 1'b1; tick(); lv1 = 1'b0;
    for (int j = 0; j < 32; j++) begin
      se1 = 1'b1; u1 = '0; tick();
      if (j == 0) chk("s0_tap", 512'(st1[495:465]), 512'h101);
    end
    se1 = 1'b0;

    // Load + step together in WORK: load captured, no step.
    load_data = '0; load_data[465] = 1'b1; lv1 = 1'b1; se1 = 1'b1; tick(); lv1 = 1'b0;
    chk("load_wins", 512'(st1), 512'(load_data));
    chk("load_wins_rdy", 512'(lr1), 512'd0);
    u1 = '0; tick(); se1 = 1'b0;
    chk("s15_tap", 512'(st1[495:465]), 512'h8000);

    // Load during INIT is ignored.
    load_data = {16{31'h1234567}}; lv1 = 1'b1; tick(); lv1 = 1'b0;
    chk("init_load_ign", 512'(st1[495:465]), 512'h8000);
    chk("init_load_rdy", 512'(lr1), 512'd0);

    for (int j = 0; j < 9; j++) begin
      se1 = 1'b1; u1 = useq(j); tick();
    end
    se1 = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_state", 512'(st1), 512'd0);
    chk("mid_rst_work", 512'(wk1), 512'd0);
    chk("mid_rst_ready", 512'(lr1), 512'd1);
    chk("mid_rst_cnt", 512'(sc1), 512'd0);

    // u path literals on both widths.
    load_data = '0; lv1 = 1'b1; lv2 = 1'b1; tick(); lv1 = 1'b0; lv2 = 1'b0;
    se1 = 1'b1; u1 = 31'd5; se2 = 1'b1; u2 = {31'd7, 31'd5}; tick();
    se1 = 1'b0; se2 = 1'b0;
    chk("u1_add", 512'(st1[495:465]), 512'd5);
    chk("u2_first", 512'(st2[464:434]), 512'd5);
    chk("u2_second", 512'(st2[495:465]), 512'h28007);
    rst = 1'b1; tick(); rst = 1'b0;

    // Lockstep: one STEPS=2 step per two STEPS=1 steps on the same u sequence.
    for (int i = 0; i < 16; i++) load_data[31*i +: 31] = useq(100 + i);
    lv1 = 1'b1; lv2 = 1'b1; tick(); lv1 = 1'b0; lv2 = 1'b0;
    for (int j = 0; j < 40; j++) begin
      se1 = 1'b1; u1 = useq(j);
      se2 = j[0];
      u2 = {useq(j), useq(j - 1)};
      tick();
      if (j[0]) chk("steps2_eq_1", 512'(st2), 512'(mpack(0)));
      if (j == 29) chk("done2_early", 512'(id2), 512'd0);
      if (j == 31) begin
        chk("done2_16", 512'(id2), 512'd1);
        chk("work2_16", 512'(wk2), 512'd1);
        chk("done1_lock", 512'(id1), 512'd1);
      end
    end
    se1 = 1'b0; se2 = 1'b0;
    tick();
    tick();
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
